// File: rtl/multdiv_exec_unit.sv
// Iterative signed multiply/divide unit beside the X stage: radix-2 shift-add
// multiply and restoring divide on operand magnitudes, with a held writeback port.
module multdiv_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int REG_W    = 5,
    parameter int EXC_REG  = 30,
    parameter int MULT_EXC = 4,
    parameter int DIV_EXC  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_issue_valid,
    output logic             o_issue_ready,
    input  logic             i_issue_op,
    input  logic [WIDTH-1:0] i_issue_a,
    input  logic [WIDTH-1:0] i_issue_b,
    input  logic [REG_W-1:0] i_issue_rd,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [REG_W-1:0] o_wb_rd,
    output logic [WIDTH-1:0] o_wb_data,
    output logic             o_wb_exc
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_op;
    logic               r_neg;
    logic               r_dz;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [REG_W-1:0]   r_rd;
    logic [REG_W-1:0]   r_wb_rd;
    logic [WIDTH-1:0]   r_wb_data;
    logic               r_wb_exc;

    logic               w_accept;
    logic               w_div0;
    logic               w_last;
    logic               w_finish;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH-1:0]   w_quo;
    logic               w_mul_ovf;

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cond_neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? ('0 - v) : v;
    endfunction

    // A signed product fits in WIDTH bits only if its top WIDTH+1 bits are all equal.
    function automatic logic f_mul_ovf(input logic [2*WIDTH-1:0] p);
        return !((&p[2*WIDTH-1:WIDTH-1]) || (~|p[2*WIDTH-1:WIDTH-1]));
    endfunction

    assign o_issue_ready = (r_state == S_IDLE) ||
                           ((r_state == S_DONE) && i_wb_ready && !i_flush);
    assign w_accept      = i_issue_valid && o_issue_ready && !i_flush;
    assign w_div0        = i_issue_op && (i_issue_b == '0);
    assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_finish      = (r_state == S_RUN) && (r_dz || w_last);

    assign w_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo = r_acc[WIDTH-1:0];

    // Multiply: {hi,lo} holds partial product over the shrinking multiplier.
    assign w_madd    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_madd, w_lo[WIDTH-1:1]};

    // Divide: {hi,lo} holds remainder over the dividend being shifted into quotient.
    assign w_shift   = {w_hi, w_lo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_ge      = !w_diff[WIDTH];
    assign w_div_nxt = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                        w_lo[WIDTH-2:0], w_ge};

    assign w_acc_nxt = r_op ? w_div_nxt : w_mul_nxt;
    assign w_prod    = f_cond_neg_2w(r_neg, w_mul_nxt);
    assign w_quo     = f_cond_neg_w(r_neg, w_div_nxt[WIDTH-1:0]);
    assign w_mul_ovf = f_mul_ovf(w_prod);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN:  if (r_dz || w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                if (i_wb_ready) w_state_nxt = S_IDLE;
                if (w_accept)   w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
                r_dz  <= w_div0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_acc <= {{WIDTH{1'b0}}, f_abs(i_issue_a)};
            r_b   <= f_abs(i_issue_b);
            r_op  <= i_issue_op;
            r_neg <= i_issue_a[WIDTH-1] ^ i_issue_b[WIDTH-1];
            r_rd  <= i_issue_rd;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Writeback registers load only on the edge that enters DONE and then hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_exc  <= 1'b0;
        end else if (w_finish && !i_flush) begin
            if (r_dz) begin
                r_wb_rd   <= REG_W'(EXC_REG);
                r_wb_data <= WIDTH'(DIV_EXC);
                r_wb_exc  <= 1'b1;
            end else if (!r_op && w_mul_ovf) begin
                r_wb_rd   <= REG_W'(EXC_REG);
                r_wb_data <= WIDTH'(MULT_EXC);
                r_wb_exc  <= 1'b1;
            end else begin
                r_wb_rd   <= r_rd;
                r_wb_data <= r_op ? w_quo : w_prod[WIDTH-1:0];
                r_wb_exc  <= 1'b0;
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_wb_valid = (r_state == S_DONE);
    assign o_wb_exc   = (r_state == S_DONE) && r_wb_exc;
    assign o_wb_rd    = r_wb_rd;
    assign o_wb_data  = r_wb_data;

endmodule

// File: tb/tb_multdiv_exec_unit.sv
// Directed bench for multdiv_exec_unit: latency, signed results, exceptions,
// writeback backpressure with back-to-back issue, flush and async reset.
module tb_multdiv_exec_unit;

    localparam int WIDTH = 32;
    localparam int REG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic             issue_op;
    logic [WIDTH-1:0] issue_a;
    logic [WIDTH-1:0] issue_b;
    logic [REG_W-1:0] issue_rd;
    logic             flush;
    logic             busy;
    logic             wb_valid;
    logic             wb_ready;
    logic [REG_W-1:0] wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             wb_exc;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;
    int seen;

    multdiv_exec_unit #(
        .WIDTH(WIDTH), .REG_W(REG_W), .EXC_REG(30), .MULT_EXC(4), .DIV_EXC(5)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_issue_valid(issue_valid),
        .o_issue_ready(issue_ready),
        .i_issue_op   (issue_op),
        .i_issue_a    (issue_a),
        .i_issue_b    (issue_b),
        .i_issue_rd   (issue_rd),
        .i_flush      (flush),
        .o_busy       (busy),
        .o_wb_valid   (wb_valid),
        .i_wb_ready   (wb_ready),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_data),
        .o_wb_exc     (wb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_issue(input logic op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [REG_W-1:0] rd);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        @(posedge clk);
        #1 issue_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_valid && n < 100);
    endtask

    task automatic run_chk(input string tag, input logic op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [REG_W-1:0] rd,
                           input int exp_lat, input logic [REG_W-1:0] exp_rd,
                           input logic [WIDTH-1:0] exp_data, input logic exp_exc);
        int l;
        do_issue(op, a, b, rd);
        wait_wb(l);
        chk_val({tag, "_lat"}, l, exp_lat);
        chk_val({tag, "_res"}, {busy, wb_exc, wb_rd, wb_data}, {1'b1, exp_exc, exp_rd, exp_data});
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = 1'b0;
        issue_a     = '0;
        issue_b     = '0;
        issue_rd    = '0;
        flush       = 1'b0;
        wb_ready    = 1'b1;

        repeat (2) @(posedge clk);
        #1 chk_val("reset", {issue_ready, busy, wb_valid, wb_exc, wb_rd, wb_data},
                   {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
        @(negedge clk) rst_n = 1'b1;

        run_chk("mul_6x7", 1'b0, 32'd6, 32'd7, 5'd3, WIDTH, 5'd3, 32'd42, 1'b0);
        @(posedge clk);
        #1 chk_val("retire_idle", {busy, wb_valid, issue_ready}, 3'b001);

        run_chk("div_m8_3", 1'b1, 32'hFFFF_FFF8, 32'd3, 5'd5, WIDTH, 5'd5, 32'hFFFF_FFFE, 1'b0);
        run_chk("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd6, WIDTH, 5'd6, 32'hFFFF_FFFD, 1'b0);
        run_chk("div_9_0", 1'b1, 32'd9, 32'd0, 5'd4, 1, 5'd30, 32'd5, 1'b1);
        run_chk("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd2, WIDTH, 5'd30, 32'd4, 1'b1);
        run_chk("mul_m1m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, WIDTH, 5'd1, 32'd1, 1'b0);
        run_chk("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, WIDTH, 5'd9, 32'h8000_0000, 1'b0);
        run_chk("mul_min_1", 1'b0, 32'h8000_0000, 32'd1, 5'd10, WIDTH, 5'd10, 32'h8000_0000, 1'b0);
        run_chk("mul_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, WIDTH, 5'd30, 32'd4, 1'b1);
        run_chk("div_100_7", 1'b1, 32'd100, 32'd7, 5'd12, WIDTH, 5'd12, 32'd14, 1'b0);

        // Backpressure: result held while the write port is withheld.
        do_issue(1'b0, 32'd3, 32'hFFFF_FFFB, 5'd7);
        wb_ready = 1'b0;
        wait_wb(lat);
        chk_val("bp_lat", lat, WIDTH);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk_val("bp_hold", {wb_valid, wb_exc, wb_rd, wb_data, issue_ready, busy},
                       {1'b1, 1'b0, 5'd7, 32'hFFFF_FFF1, 1'b0, 1'b1});
        end
        @(negedge clk);
        wb_ready    = 1'b1;
        issue_valid = 1'b1;
        issue_op    = 1'b0;
        issue_a     = 32'd2;
        issue_b     = 32'd3;
        issue_rd    = 5'd8;
        #1 chk_val("b2b_ready", issue_ready, 1'b1);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        chk_val("b2b_accept", {busy, wb_valid}, 2'b10);
        wait_wb(lat);
        chk_val("b2b_lat", lat, WIDTH);
        chk_val("b2b_res", {wb_exc, wb_rd, wb_data}, {1'b0, 5'd8, 32'd6});

        // Flush partway through a multiply drops it without a write.
        do_issue(1'b0, 32'd123, 32'd456, 5'd13);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk_val("flush_idle", {busy, issue_ready, wb_valid}, 3'b010);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (wb_valid) seen++;
        end
        chk_val("flush_no_wb", seen, 0);

        // Asynchronous reset mid-run clears outputs without waiting for an edge.
        do_issue(1'b0, 32'd5, 32'd5, 5'd14);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_val("reset_midrun", {issue_ready, busy, wb_valid, wb_exc, wb_rd, wb_data},
                   {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
        @(negedge clk) rst_n = 1'b1;

        run_chk("post_reset", 1'b1, 32'hFFFF_FF9C, 32'd10, 5'd15, WIDTH, 5'd15, 32'hFFFF_FFF6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
